// File: rtl/alu_exec_sequencer_if.sv
// alu_exec_sequencer_if: instruction handshake and ALU drive/return signals
interface alu_exec_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [1:0]        instr_rd;
    logic [1:0]        instr_rs1;
    logic [1:0]        instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_operand2;
    logic [2:0]        alu_operation;
    logic              alu_enable;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, alu_result,
        input  instr_ready, alu_operand1, alu_operand2, alu_operation, alu_enable
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, alu_result,
        output instr_ready, alu_operand1, alu_operand2, alu_operation, alu_enable
    );
endinterface

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: serial IDLE/ISSUE/WRITE sequencer feeding an 8-bit ALU from a 4x8 register file
module alu_exec_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_sequencer_if.slave  bus,
    output logic                 wb_valid,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 zero_flag,
    output logic                 err_div0,
    output logic                 err_illegal,
    input  logic [1:0]           dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;

    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b111;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0] imm_q, imm_d, result_q, result_d;
    logic              write_ok_q, write_ok_d;
    logic              zero_q, zero_d, div0_q, div0_d, ill_q, ill_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              accept, issue, legal, div_zero;

    always_comb begin
        accept     = bus.instr_ready && bus.instr_valid;
        issue      = state_q == ISSUE;
        legal      = op_q inside {OP_LDI, OP_MUL, OP_ADD, OP_SUB, OP_DIV};
        div_zero   = op_q == OP_DIV && regs_q[rs2_q] == '0;
        wb_valid   = state_q == WRITE && write_ok_q;
        state_d    = state_q == IDLE ? (accept ? ISSUE : IDLE) : issue ? WRITE : IDLE;
        op_d       = accept ? bus.instr_op : op_q;
        rd_d       = accept ? bus.instr_rd : rd_q;
        rs1_d      = accept ? bus.instr_rs1 : rs1_q;
        rs2_d      = accept ? bus.instr_rs2 : rs2_q;
        imm_d      = accept ? bus.instr_imm : imm_q;
        result_d   = issue ? (op_q == OP_LDI ? imm_q : bus.alu_result) : result_q;
        write_ok_d = issue ? legal && !div_zero : write_ok_q;
        div0_d     = accept ? 1'b0 : issue ? div_zero : div0_q;
        ill_d      = accept ? 1'b0 : issue ? !legal : ill_q;
        zero_d     = wb_valid ? result_q == '0 : zero_q;
        regs_d     = regs_q;
        if (wb_valid) regs_d[rd_q] = result_q;
    end

    // Ready is gated by rst_n so it drops the instant reset asserts
    assign bus.instr_ready   = rst_n && state_q == IDLE;
    assign bus.alu_enable    = issue;
    assign bus.alu_operation = issue ? op_q : '0;
    assign bus.alu_operand1  = issue ? regs_q[rs1_q] : '0;
    assign bus.alu_operand2  = issue ? regs_q[rs2_q] : '0;
    assign wb_data           = wb_valid ? result_q : '0;
    assign zero_flag         = zero_q;
    assign err_div0          = div0_q;
    assign err_illegal       = ill_q;
    assign dbg_data          = regs_q[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            result_q   <= '0;
            write_ok_q <= 1'b0;
            zero_q     <= 1'b0;
            div0_q     <= 1'b0;
            ill_q      <= 1'b0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            result_q   <= result_d;
            write_ok_q <= write_ok_d;
            zero_q     <= zero_d;
            div0_q     <= div0_d;
            ill_q      <= ill_d;
            regs_q     <= regs_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer: vector table, held-valid, reset-abort and random checks against a register-file model
module tb_alu_exec_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wb_valid, zero_flag, err_div0, err_illegal;
    logic [7:0] wb_data, dbg_data;
    logic [1:0] dbg_addr = 2'd0;

    alu_exec_sequencer_if bus ();

    alu_exec_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .err_div0    (err_div0),
        .err_illegal (err_illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [7:0] a, b;
        logic [2:0] o;
        a = bus.alu_operand1;
        b = bus.alu_operand2;
        o = bus.alu_operation;
        bus.alu_result = o == 3'd3 ? 8'(a + b) : o == 3'd4 ? 8'(a - b) : o == 3'd2 ? 8'(a * b) :
                         o == 3'd7 ? (b == 8'd0 ? 8'hFF : a / b) : 8'hA5;
    end

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] imm;
        logic       wbv;
        logic [7:0] wbd;
        logic       z, d0, il;
        logic [7:0] dbg;
    } vec_t;

    vec_t       vecs [15];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_regs [4];
    logic       m_zero, m_div0, m_ill, e_wbv;
    logic [7:0] e_wbd;
    logic       ov, oz, od0, oil;
    logic [7:0] od, odbg;
    logic [2:0] rnd_ops [10] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd4, 3'd2, 3'd7, 3'd7, 3'd1, 3'd5};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        m_zero = 1'b0;
        m_div0 = 1'b0;
        m_ill  = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] op, input logic [1:0] rd, rs1, rs2, input logic [7:0] imm);
        logic [7:0] a, b, r;
        logic       legal;
        a      = m_regs[rs1];
        b      = m_regs[rs2];
        legal  = op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd4 || op == 3'd7;
        m_div0 = op == 3'd7 && b == 8'd0;
        m_ill  = !legal;
        r      = op == 3'd0 ? imm : op == 3'd3 ? 8'(a + b) : op == 3'd4 ? 8'(a - b) :
                 op == 3'd2 ? 8'(a * b) : (b == 8'd0 ? 8'd0 : a / b);
        e_wbv  = legal && !m_div0;
        e_wbd  = r;
        if (e_wbv) begin
            m_regs[rd] = r;
            m_zero     = r == 8'd0;
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, rs1, rs2, input logic [7:0] imm);
        int n = 0;
        while (!bus.instr_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_issue", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_imm   = imm;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr_op    = ~op;
        bus.instr_rd    = ~rd;
        bus.instr_rs1   = ~rs1;
        bus.instr_rs2   = ~rs2;
        bus.instr_imm   = ~imm;
        chk("issue_ready", bus.instr_ready, 0);
        chk("issue_enable", bus.alu_enable, 1);
        chk("issue_operation", bus.alu_operation, op);
        chk("issue_operand1", bus.alu_operand1, m_regs[rs1]);
        chk("issue_operand2", bus.alu_operand2, m_regs[rs2]);
        @(posedge clk); #1;
        chk("write_enable", bus.alu_enable, 0);
        chk("write_ready", bus.instr_ready, 0);
        ov = wb_valid;
        od = wb_data;
        @(posedge clk); #1;
        chk("idle_wb_valid", wb_valid, 0);
        chk("idle_ready", bus.instr_ready, 1);
        oz       = zero_flag;
        od0      = err_div0;
        oil      = err_illegal;
        dbg_addr = rd;
        #1;
        odbg = dbg_data;
        model_step(op, rd, rs1, rs2, imm);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'd0, 2'd1, 2'd0, 2'd0, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05};
        vecs[1]  = '{3'd0, 2'd2, 2'd0, 2'd0, 8'h03, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03};
        vecs[2]  = '{3'd3, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 8'h08};
        vecs[3]  = '{3'd4, 2'd0, 2'd2, 2'd2, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{3'd0, 2'd1, 2'd0, 2'd0, 8'h20, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20};
        vecs[5]  = '{3'd2, 2'd3, 2'd1, 2'd1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{3'd0, 2'd3, 2'd0, 2'd0, 8'h77, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h77};
        vecs[7]  = '{3'd0, 2'd1, 2'd0, 2'd0, 8'h09, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 8'h09};
        vecs[8]  = '{3'd0, 2'd2, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{3'd7, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h77};
        vecs[10] = '{3'd0, 2'd2, 2'd0, 2'd0, 8'h03, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03};
        vecs[11] = '{3'd7, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03};
        vecs[12] = '{3'd5, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{3'd6, 2'd1, 2'd1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09};
        vecs[14] = '{3'd3, 2'd0, 2'd1, 2'd1, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'h12};

        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_rd    = 2'd0;
        bus.instr_rs1   = 2'd0;
        bus.instr_rs2   = 2'd0;
        bus.instr_imm   = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", bus.instr_ready, 0);
        chk("reset_enable", bus.alu_enable, 0);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_flags", {zero_flag, err_div0, err_illegal}, 0);
        chk("reset_dbg", dbg_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_ready", bus.instr_ready, 1);

        for (int i = 0; i < 15; i++) begin
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            chk($sformatf("vec%0d_wb_valid", i), ov, vecs[i].wbv);
            if (vecs[i].wbv) chk($sformatf("vec%0d_wb_data", i), od, vecs[i].wbd);
            chk($sformatf("vec%0d_zero", i), oz, vecs[i].z);
            chk($sformatf("vec%0d_div0", i), od0, vecs[i].d0);
            chk($sformatf("vec%0d_illegal", i), oil, vecs[i].il);
            chk($sformatf("vec%0d_dbg", i), odbg, vecs[i].dbg);
        end

        bus.instr_op    = 3'd0;
        bus.instr_rd    = 2'd2;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.instr_imm = 8'(i + 1);
            chk($sformatf("held_ready%0d", i), bus.instr_ready, i % 3 == 0);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        dbg_addr = 2'd2;
        #1;
        chk("held_last_value", dbg_data, 8'h07);
        chk("held_zero", zero_flag, 0);
        m_regs[2] = 8'h07;
        m_zero = 1'b0;
        m_div0 = 1'b0;
        m_ill  = 1'b0;

        bus.instr_op    = 3'd3;
        bus.instr_rd    = 2'd0;
        bus.instr_rs1   = 2'd1;
        bus.instr_rs2   = 2'd2;
        bus.instr_valid = 1'b1;
        @(posedge clk); #2;
        bus.instr_valid = 1'b0;
        chk("abort_issue_enable", bus.alu_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", bus.instr_ready, 0);
        chk("abort_enable", bus.alu_enable, 0);
        chk("abort_operation", bus.alu_operation, 0);
        chk("abort_operands", {bus.alu_operand1, bus.alu_operand2}, 0);
        chk("abort_wb", {wb_valid, wb_data}, 0);
        chk("abort_flags", {zero_flag, err_div0, err_illegal}, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("abort_reg%0d", i), dbg_data, 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post_abort_ready", bus.instr_ready, 1);
            chk("post_abort_wb_valid", wb_valid, 0);
            @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [1:0] rd, rs1, rs2;
            logic [7:0] imm;
            op  = rnd_ops[$urandom_range(0, 9)];
            rd  = 2'($urandom_range(0, 3));
            rs1 = 2'($urandom_range(0, 3));
            rs2 = 2'($urandom_range(0, 3));
            imm = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(0, 255));
            run_instr(op, rd, rs1, rs2, imm);
            chk("rnd_wb_valid", ov, e_wbv);
            if (e_wbv) chk("rnd_wb_data", od, e_wbd);
            chk("rnd_zero", oz, m_zero);
            chk("rnd_div0", od0, m_div0);
            chk("rnd_illegal", oil, m_ill);
            chk("rnd_dbg", odbg, m_regs[rd]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Execute-stage sequencer placed directly upstream of the 8-bit ALU.
- Accepts one instruction per handshake and reads the two source operands from a local 4x8 register file.
- Drives the ALU operand, operation and enable inputs, captures the ALU result, and writes it back to the destination register.
- Also updates the zero and error flags and provides a combinational debug read port.

Parameters:
- NUM_REGS, 4, register file depth. Fixed at 4; the register index width is 2.
- DATA_W, 8, datapath width. Must equal the ALU width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- instr_op  in  3  operation code: 000 LDI, 011 ADD, 100 SUB, 010 MUL, 111 DIV. All other codes are illegal.
- instr_rd  in  2  destination register index.
- instr_rs1  in  2  source register 1 index.
- instr_rs2  in  2  source register 2 index.
- instr_imm  in  8  immediate, used only by LDI.
- alu_operand1  out  8  to ALU operand1.
- alu_operand2  out  8  to ALU operand2.
- alu_operation  out  3  to ALU operation.
- alu_enable  out  1  to ALU enable.
- alu_result  in  8  from ALU result (combinational).
- wb_valid  out  1  one-cycle pulse when a register is written.
- wb_data  out  8  value written; valid when wb_valid=1.
- zero_flag  out  1  last written value was 0x00.
- err_div0  out  1  last instruction was DIV with a zero divisor.
- err_illegal  out  1  last instruction had an illegal opcode.
- dbg_addr  in  2  debug register index.
- dbg_data  out  8  combinational read of regs[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all regs=0x00, latched instruction=0.
  - alu_operand1/2=0, alu_operation=0, alu_enable=0.
  - wb_valid=0, wb_data=0, all flags=0.
  - instr_ready deasserts immediately while in reset.
- FSM states: IDLE, ISSUE, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready: latch op, rd, rs1, rs2, imm; clear err_div0 and err_illegal; go to ISSUE.
- ISSUE (exactly 1 cycle, instr_ready=0):
  - alu_enable=1, alu_operation=latched op, alu_operand1=regs[rs1], alu_operand2=regs[rs2].
  - At the clock edge, capture a result into result_q:
    - LDI: capture imm; the ALU value is ignored.
    - Legal ALU op: capture alu_result.
  - Set write_ok=0 and the matching error flag when either:
    - op is DIV and regs[rs2]==0 (err_div0=1), or
    - op is illegal (err_illegal=1).
  - Otherwise write_ok=1.
  - Always go to WRITE.
- WRITE (exactly 1 cycle, instr_ready=0):
  - If write_ok: regs[rd]<=result_q, wb_valid=1, wb_data=result_q, zero_flag<=(result_q==0).
  - If not write_ok: no register write, wb_valid=0, zero_flag holds.
  - Go to IDLE.
- ALU outputs outside ISSUE: alu_enable=0, operands and operation=0.
- Arithmetic: the result width is 8 bits. Truncation of MUL and wrap of ADD/SUB are inherited from the ALU and are not checked here.
- Throughput and latency:
  - Handshake at edge N.
  - Register write and wb_valid at the edge N+2 / cycle N+2.
  - instr_ready high again in cycle N+3, so peak throughput is 1 instruction per 3 cycles.
- Hazards:
  - rd==rs1 or rd==rs2 is legal; the operands are read in ISSUE, before the write.
  - No forwarding is required because execution is serial.
- instr_valid is ignored while instr_ready=0. The upstream block must hold it, and fields are sampled only at the handshake.
- dbg_data reflects the new register value from the cycle after the WRITE edge.
- Reset mid-operation (ISSUE or WRITE) aborts the instruction: no write occurs and the block returns to IDLE.
- Flags persist until the next handshake (errors) or the next successful write (zero).

Test Plan:
- LDI r1=0x05, then LDI r2=0x03, then ADD r3=r1+r2:
  - wb_data=0x08 two cycles after the ADD handshake.
  - dbg_addr=3 reads 0x08; zero_flag=0.
- SUB r0=r2-r2 with r2=0x03:
  - alu_operation=100 and alu_enable=1 for exactly 1 cycle.
  - r0=0x00, zero_flag=1.
- MUL r3=r1*r1 with r1=0x20:
  - wb_data=0x00 (truncated), zero_flag=1.
- DIV with r1=0x09 and divisor r2=0x00:
  - err_div0=1, no wb_valid pulse, r-dest unchanged.
  - A following DIV r3=r1/r2 with r2=0x03 gives 0x03 and clears err_div0.
- Illegal op 101:
  - err_illegal=1, no write, the FSM returns to IDLE on schedule.
  - Back-to-back held instr_valid is accepted only every 3 cycles.
- Assert rst_n=0 during ISSUE of an ADD:
  - Outputs go to 0 asynchronously and all regs read 0x00.
  - After release, instr_ready=1 and no wb_valid is seen for the aborted instruction.
